// File: rtl/div_unit_pkg.sv
// Shared divider definitions: width, div_op encodings, FSM states and op decode helpers.
package div_unit_pkg;
  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return !op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction
endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between EX-stage control and the divider.
interface div_unit_if;
  import div_unit_pkg::*;

  logic            start;
  logic [1:0]      div_op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] res;

  modport master (output start, div_op, op_a, op_b, flush, input busy, done, res);
  modport slave  (input start, div_op, op_a, op_b, flush, output busy, done, res);
endinterface

// File: rtl/div_unit_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_unit_step
  import div_unit_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // rem < divisor on entry, so the shifted remainder always fits in XLEN+1 bits
  always_comb begin
    rem_sh = {rem, quo[XLEN-1]};
    diff   = rem_sh - {1'b0, divisor};
    if (diff[XLEN]) begin
      rem_nxt = rem_sh[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_nxt = diff[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 RV32M divider: 33-cycle latency (special cases 1 cycle), start ignored while busy.
// Define DIV_REUSE_EN to keep the last result pair so DIV/REM on the same operands completes in 1 cycle.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  dif
);
  state_e            state;
  logic [CNT_W-1:0]  count;
  logic [XLEN-1:0]   rem_q, quo_q, dvs_q, res_q;
  logic              neg_q, neg_r, is_rem, busy_q, done_q;

  logic              sgn_in, rem_in, is_special;
  logic [XLEN-1:0]   abs_a, abs_b, spec_res;
  logic [XLEN-1:0]   rem_nxt, quo_nxt, fix_q, fix_r;

  div_unit_step u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_comb begin
    sgn_in     = op_is_signed(dif.div_op);
    rem_in     = op_is_rem(dif.div_op);
    abs_a      = (sgn_in && dif.op_a[XLEN-1]) ? -dif.op_a : dif.op_a;
    abs_b      = (sgn_in && dif.op_b[XLEN-1]) ? -dif.op_b : dif.op_b;
    is_special = 1'b0;
    spec_res   = '0;
    if (dif.op_b == '0) begin
      is_special = 1'b1;
      spec_res   = rem_in ? dif.op_a : '1;
    end else if (sgn_in && dif.op_a == {1'b1, {(XLEN-1){1'b0}}} && dif.op_b == '1) begin
      is_special = 1'b1;
      spec_res   = rem_in ? '0 : dif.op_a;
    end
    fix_q = neg_q ? -quo_nxt : quo_nxt;
    fix_r = neg_r ? -rem_nxt : rem_nxt;
  end

`ifdef DIV_REUSE_EN
  logic [XLEN-1:0] a_q, b_q, c_a, c_b, c_quo, c_rem;
  logic            sgn_q, c_sgn, c_vld, hit;
  always_comb hit = c_vld && c_a == dif.op_a && c_b == dif.op_b && c_sgn == sgn_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      count  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      res_q  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_rem <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef DIV_REUSE_EN
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      c_a    <= '0;
      c_b    <= '0;
      c_quo  <= '0;
      c_rem  <= '0;
      c_sgn  <= 1'b0;
      c_vld  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (dif.flush) begin
        state  <= S_IDLE;
        busy_q <= 1'b0;
        count  <= '0;
`ifdef DIV_REUSE_EN
        if (state == S_CALC) c_vld <= 1'b0;
`endif
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            state <= S_IDLE;
            if (dif.start) begin
              if (is_special) begin
                res_q  <= spec_res;
                done_q <= 1'b1;
                state  <= S_DONE;
              end
`ifdef DIV_REUSE_EN
              else if (hit) begin
                res_q  <= rem_in ? c_rem : c_quo;
                done_q <= 1'b1;
                state  <= S_DONE;
              end
`endif
              else begin
                state  <= S_CALC;
                busy_q <= 1'b1;
                count  <= CNT_W'(XLEN);
                rem_q  <= '0;
                quo_q  <= abs_a;
                dvs_q  <= abs_b;
                neg_q  <= sgn_in && (dif.op_a[XLEN-1] ^ dif.op_b[XLEN-1]);
                neg_r  <= sgn_in && dif.op_a[XLEN-1];
                is_rem <= rem_in;
`ifdef DIV_REUSE_EN
                a_q    <= dif.op_a;
                b_q    <= dif.op_b;
                sgn_q  <= sgn_in;
`endif
              end
            end
          end
          S_CALC: begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              state  <= S_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              res_q  <= is_rem ? fix_r : fix_q;
`ifdef DIV_REUSE_EN
              c_a    <= a_q;
              c_b    <= b_q;
              c_sgn  <= sgn_q;
              c_quo  <= fix_q;
              c_rem  <= fix_r;
              c_vld  <= 1'b1;
`endif
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign dif.busy = busy_q;
  assign dif.done = done_q;
  assign dif.res  = res_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against an arithmetic reference model.
module tb_div_unit;
  import div_unit_pkg::*;

`ifdef DIV_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if dif ();
  div_unit dut (.clk(clk), .rst(rst), .dif(dif.slave));

  int          checks = 0;
  int          errors = 0;
  logic [31:0] prev_res;
  logic [31:0] c_a, c_b;
  logic        c_s, c_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    return op[1] ? a % b : a / b;
  endfunction

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    dif.start  = 1'b1;
    dif.div_op = op;
    dif.op_a   = a;
    dif.op_b   = b;
  endtask

  // Called at the negedge of the start cycle; returns at the negedge of the done cycle.
  task automatic wait_done(input int lat, input int nbusy_exp, input logic [31:0] exp, input string tag);
    int k, nbusy;
    k = 0;
    nbusy = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      dif.start = 1'b0;
      if (dif.done) break;
      if (dif.busy) nbusy++;
    end
    chk({tag, "_lat"}, 32'(k), 32'(lat));
    chk({tag, "_busycyc"}, 32'(nbusy), 32'(nbusy_exp));
    chk({tag, "_busy_at_done"}, {31'd0, dif.busy}, 32'd0);
    chk({tag, "_res"}, dif.res, exp);
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input string tag);
    int lat;
    if (is_special(op, a, b)) lat = 1;
    else if (REUSE && c_v && c_a == a && c_b == b && c_s == !op[0]) lat = 1;
    else begin
      lat = 33;
      c_v = 1'b1;
      c_a = a;
      c_b = b;
      c_s = !op[0];
    end
    launch(op, a, b);
    wait_done(lat, (lat == 33) ? 32 : 0, exp, tag);
    prev_res = exp;
  endtask

  initial begin
    int ndone, mode;
    logic [1:0]  op;
    logic [31:0] a, b;
    dif.start  = 1'b0;
    dif.div_op = 2'b00;
    dif.op_a   = '0;
    dif.op_b   = '0;
    dif.flush  = 1'b0;
    c_v = 1'b0; c_a = '0; c_b = '0; c_s = 1'b0;
    prev_res = '0;
    a = '0; b = '0;
    rst = 1'b1;
    #12;
    chk("rst_busy", {31'd0, dif.busy}, 32'd0);
    chk("rst_done", {31'd0, dif.done}, 32'd0);
    chk("rst_res", dif.res, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(DIV_OP_DIV,  32'd100, 32'd7, 32'd14, "div_100_7");
    run(DIV_OP_REM,  -32'd100, 32'd7, 32'hFFFF_FFFE, "rem_m100_7");
    run(DIV_OP_DIV,  32'd100, -32'd7, 32'hFFFF_FFF2, "div_100_m7");
    run(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, "divu_max_2");
    run(DIV_OP_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, "divu_by0");
    run(DIV_OP_REMU, 32'h1234, 32'd0, 32'h0000_1234, "remu_by0");
    run(DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run(DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");

    // Flush in cycle 10 of a fresh operation
    @(negedge clk);
    launch(DIV_OP_DIV, 32'd100, 32'd13);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      dif.start = 1'b0;
    end
    dif.flush = 1'b1;
    @(negedge clk);
    dif.flush = 1'b0;
    chk("flush_busy", {31'd0, dif.busy}, 32'd0);
    chk("flush_done", {31'd0, dif.done}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dif.done) ndone++;
    end
    chk("flush_no_done", 32'(ndone), 32'd0);
    chk("flush_res_held", dif.res, prev_res);
    c_v = 1'b0;
    run(DIV_OP_DIV, 32'd9, 32'd3, 32'd3, "div_9_3_after_flush");

    // Start while busy must be ignored
    @(negedge clk);
    launch(DIV_OP_DIV, 32'd1000, 32'd7);
    c_v = 1'b1; c_a = 32'd1000; c_b = 32'd7; c_s = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      dif.start = 1'b0;
    end
    launch(DIV_OP_DIVU, 32'd50, 32'd5);
    wait_done(28, 27, 32'd142, "start_in_calc");
    prev_res = 32'd142;

    // Asynchronous reset mid-calculation
    @(negedge clk);
    launch(DIV_OP_DIVU, 32'd12345, 32'd11);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      dif.start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, dif.busy}, 32'd0);
    chk("arst_done", {31'd0, dif.done}, 32'd0);
    chk("arst_res", dif.res, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    c_v = 1'b0;
    prev_res = '0;
    @(negedge clk);

    // Back-to-back: REM issued in the DIV done cycle
    run(DIV_OP_DIV, 32'd100, 32'd7, 32'd14, "b2b_div");
    run(DIV_OP_REM, 32'd100, 32'd7, 32'd2, "b2b_rem");

    for (int i = 0; i < 24; i++) begin
      op   = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 5);
      case (mode)
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = $urandom; b = $urandom_range(1, 20); end
        2: begin a = $urandom; b = $urandom; end
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: begin end
        default: begin
          a = $urandom_range(0, 100);
          b = $urandom_range(1, 100);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
      endcase
      if ($urandom_range(0, 2) == 0) @(negedge clk);
      run(op, a, b, model(op, a, b), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
